// File: rtl/stopwatch_bcd.sv
// stopwatch_bcd: mm:ss BCD stopwatch on a synchronized 1 s toggle; STOPWATCH_LAP_EN adds a lap-hold display snapshot
module stopwatch_bcd #(
    parameter int MAX_MIN   = 59,
    parameter bit EDGE_BOTH = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       wrap
);
    localparam logic [3:0] MT = 4'(MAX_MIN / 10);
    localparam logic [3:0] MO = 4'(MAX_MIN % 10);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
    state_t r_state, w_req, w_state_nxt;
    logic r_s1, r_s2, r_s3, r_ss_cur, r_ss_prev, r_running, r_wrap;
    logic [1:0] r_prime;
    logic [3:0] r_so, r_st, r_mo, r_mt;
    logic w_tick, w_rise, w_cnt, w_c0, w_c1, w_c2, w_max, w_zero_nxt;
    logic [15:0] w_live;
    assign w_live = {r_mt, r_mo, r_st, r_so};
    // ticks are ignored until the prime counter saturates after reset
    assign w_tick = (EDGE_BOTH ? (r_s2 ^ r_s3) : (r_s2 & ~r_s3)) && r_prime == 2'd3;
    assign w_rise = r_ss_cur & ~r_ss_prev;
    assign w_cnt = w_tick && r_state == RUN && !clear;
    assign w_c0 = r_so == 4'd9;
    assign w_c1 = w_c0 && r_st == 4'd5;
    assign w_c2 = w_c1 && r_mo == 4'd9;
    assign w_max = w_c1 && r_mo == MO && r_mt == MT;
    assign w_zero_nxt = clear || (w_cnt ? w_max : w_live == 16'd0);
    // leaving RUN with a zero count lands in IDLE, since PAUSE implies a nonzero count
    assign w_req = w_rise ? (r_state == RUN ? PAUSE : RUN) : r_state;
    assign w_state_nxt = (w_req == PAUSE && w_zero_nxt) ? IDLE : w_req;
    always_ff @(posedge clk) begin
        if (rst) begin
            {r_s1, r_s2, r_s3, r_ss_cur, r_ss_prev, r_running, r_wrap} <= '0;
            r_prime <= '0;
            {r_mt, r_mo, r_st, r_so} <= '0;
            r_state <= IDLE;
        end else begin
            r_s1 <= tick_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            if (r_prime != 2'd3) r_prime <= r_prime + 2'd1;
            r_ss_cur <= start_stop;
            r_ss_prev <= r_ss_cur;
            r_wrap <= w_cnt && w_max;
            r_state <= w_state_nxt;
            r_running <= w_state_nxt == RUN;
            if (clear) begin
                {r_mt, r_mo, r_st, r_so} <= '0;
            end else if (w_cnt) begin
                r_so <= w_c0 ? 4'd0 : r_so + 4'd1;
                if (w_c0) r_st <= w_c1 ? 4'd0 : r_st + 4'd1;
                if (w_c1) r_mo <= (w_c2 || w_max) ? 4'd0 : r_mo + 4'd1;
                if (w_c1) r_mt <= w_max ? 4'd0 : (w_c2 ? r_mt + 4'd1 : r_mt);
            end
        end
    end
    assign running = r_running;
    assign wrap = r_wrap;
`ifdef STOPWATCH_LAP_EN
    logic r_lap_cur, r_lap_prev, r_hold;
    logic [15:0] r_snap;
    always_ff @(posedge clk) begin
        if (rst) begin
            {r_lap_cur, r_lap_prev, r_hold} <= '0;
            r_snap <= '0;
        end else begin
            r_lap_cur <= lap;
            r_lap_prev <= r_lap_cur;
            if (clear) begin
                r_hold <= 1'b0;
            end else if (r_lap_cur & ~r_lap_prev) begin
                r_hold <= ~r_hold;
                r_snap <= w_live;
            end
        end
    end
    assign {min_tens, min_ones, sec_tens, sec_ones} = r_hold ? r_snap : w_live;
`else
    logic w_unused;
    assign w_unused = lap;
    assign {min_tens, min_ones, sec_tens, sec_ones} = w_live;
`endif
endmodule

// File: tb/tb_stopwatch_bcd.sv
// tb_stopwatch_bcd: directed checks of reset, latency, carry, rollover, pause, clear priority and lap hold
module tb_stopwatch_bcd;
    logic clk = 0, rst = 1, tick_in = 1, start_stop = 0, clear = 0, lap = 0;
    logic [3:0] so, st, mo, mt, so1, st1, mo1, mt1;
    logic running, wrap, running1, wrap1;
    int n_run = 0, n_fail = 0;
    logic [15:0] cnt, cnt1;
    assign cnt = {mt, mo, st, so};
    assign cnt1 = {mt1, mo1, st1, so1};

    stopwatch_bcd u_dut (
        .clk(clk), .rst(rst), .tick_in(tick_in), .start_stop(start_stop), .clear(clear), .lap(lap),
        .sec_ones(so), .sec_tens(st), .min_ones(mo), .min_tens(mt), .running(running), .wrap(wrap)
    );
    stopwatch_bcd #(.MAX_MIN(1)) u_dut1 (
        .clk(clk), .rst(rst), .tick_in(tick_in), .start_stop(start_stop), .clear(clear), .lap(lap),
        .sec_ones(so1), .sec_tens(st1), .min_ones(mo1), .min_tens(mt1), .running(running1), .wrap(wrap1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tog();
        tick_in = ~tick_in;
        step(8);
    endtask

    task automatic press();
        start_stop = 1;
        step(2);
        start_stop = 0;
        step(2);
    endtask

    function automatic logic [15:0] to_bcd(input int s);
        int m, x;
        m = s / 60;
        x = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
    endfunction

    initial begin
        step(2);
        rst = 0;
        step(10);
        check("reset_cnt", 32'(cnt), 32'h0000);
        check("reset_run", 32'(running), 0);
        check("reset_wrap", 32'(wrap), 0);
        check("reset_cnt1", 32'(cnt1), 32'h0000);
        start_stop = 1;
        step(1);
        check("start_lat", 32'(running), 0);
        step(1);
        check("start_run", 32'(running), 1);
        start_stop = 0;
        step(4);
        for (int i = 1; i <= 61; i++) begin
            tick_in = ~tick_in;
            step(2);
            check("lat_hold", 32'(cnt), 32'(to_bcd(i - 1)));
            step(1);
            check("lat_upd", 32'(cnt), 32'(to_bcd(i)));
            step(5);
        end
        check("carry_0101", 32'(cnt), 32'h0101);
        for (int i = 62; i <= 119; i++) tog();
        check("pre_roll", 32'(cnt), 32'h0159);
        check("pre_roll1", 32'(cnt1), 32'h0159);
        tick_in = ~tick_in;
        step(2);
        check("wrap1_early", 32'(wrap1), 0);
        step(1);
        check("roll_cnt1", 32'(cnt1), 32'h0000);
        check("roll_wrap1", 32'(wrap1), 1);
        check("roll_run1", 32'(running1), 1);
        check("noroll_cnt", 32'(cnt), 32'h0200);
        check("noroll_wrap", 32'(wrap), 0);
        step(1);
        check("wrap1_once", 32'(wrap1), 0);
        step(4);
        tog();
        check("post_roll", 32'(cnt), 32'h0201);
        press();
        check("pause_run", 32'(running), 0);
        repeat (3) tog();
        check("pause_hold", 32'(cnt), 32'h0201);
        press();
        check("resume_run", 32'(running), 1);
        tog();
        check("resume_cnt", 32'(cnt), 32'h0202);
        press();
        check("pause2_run", 32'(running), 0);
        tick_in = ~tick_in;
        step(1);
        start_stop = 1;
        step(2);
        check("coll_run", 32'(running), 1);
        start_stop = 0;
        step(5);
        check("coll_cnt", 32'(cnt), 32'h0202);
        tog();
        check("coll_after", 32'(cnt), 32'h0203);
        clear = 1;
        step(1);
        clear = 0;
        check("clr_cnt", 32'(cnt), 32'h0000);
        check("clr_run", 32'(running), 1);
        step(4);
        repeat (7) tog();
        check("pre_clr_run", 32'(cnt), 32'h0007);
        tick_in = ~tick_in;
        step(2);
        clear = 1;
        step(1);
        clear = 0;
        check("clrtick_cnt", 32'(cnt), 32'h0000);
        check("clrtick_run", 32'(running), 1);
        step(5);
        check("clrtick_drop", 32'(cnt), 32'h0000);
        repeat (7) tog();
        check("pre_clr_pause", 32'(cnt), 32'h0007);
        press();
        check("pause3_run", 32'(running), 0);
        tick_in = ~tick_in;
        step(2);
        clear = 1;
        step(1);
        clear = 0;
        check("clrp_cnt", 32'(cnt), 32'h0000);
        check("clrp_run", 32'(running), 0);
        step(5);
        press();
        check("idle_start", 32'(running), 1);
        repeat (5) tog();
        check("pre_lap", 32'(cnt), 32'h0005);
        lap = 1;
        step(2);
        lap = 0;
        step(2);
        repeat (4) tog();
`ifdef STOPWATCH_LAP_EN
        check("lap_frozen", 32'(cnt), 32'h0005);
`else
        check("lap_ignored", 32'(cnt), 32'h0009);
`endif
        lap = 1;
        step(2);
        lap = 0;
        step(2);
        check("lap_release", 32'(cnt), 32'h0009);
        rst = 1;
        step(1);
        rst = 0;
        check("midrst_cnt", 32'(cnt), 32'h0000);
        check("midrst_run", 32'(running), 0);
        check("midrst_wrap", 32'(wrap), 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
